// File: rtl/pwm_fader_pkg.sv
// Shared types for the breathing PWM sequencer.
package pwm_fader_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_UP      = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_DOWN    = 3'd3,
      ST_HOLD_LO = 3'd4
   } fader_state_t;
endpackage

// File: rtl/pwm_fader_tick_div.sv
// Step divider: one tick every div+1 cycles while run is high.
module tick_div #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic [W-1:0] div,
   output logic         tick
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run || cnt_q == div) cnt_d = '0;
   end

   assign tick = run && (cnt_q == div);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pwm_fader.sv
// Triangle duty sequencer for a pwm instance; duty moves only on frame ends.
module pwm_fader
   import pwm_fader_pkg::*;
#(
   parameter int N     = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] step_div,
   input  logic [N-1:0]     duty_min,
   input  logic [N-1:0]     duty_max,
   input  logic [N-1:0]     delta,
   input  logic [DIV_W-1:0] hold,
   output logic             pwm_ena,
   output logic             pwm_step,
   output logic [N-1:0]     pwm_duty,
   output logic             busy
);
   fader_state_t     state_q, state_d;
   logic [N-1:0]     duty_q, duty_d;
   logic [N-1:0]     frm_q, frm_d;
   logic [N-1:0]     min_q, min_d;
   logic [N-1:0]     max_q, max_d;
   logic [N-1:0]     dlt_q, dlt_d;
   logic [DIV_W-1:0] hcfg_q, hcfg_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] hcnt_q, hcnt_d;
   logic             busy_q, busy_d;
   logic             tick, fe;
   logic [N:0]       up_sum;
   logic [N-1:0]     up_nxt, dn_nxt;
   logic signed [N:0] dn_diff;

   tick_div #(.W(DIV_W)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .run  (busy_q),
      .div  (div_q),
      .tick (tick)
   );

   assign pwm_step = tick;
   assign pwm_ena  = busy_q;
   assign busy     = busy_q;
   assign pwm_duty = duty_q;
   assign fe       = tick && (&frm_q);

   assign up_sum  = {1'b0, duty_q} + {1'b0, dlt_q};
   assign up_nxt  = (up_sum > {1'b0, max_q}) ? max_q : up_sum[N-1:0];
   assign dn_diff = $signed({1'b0, duty_q}) - $signed({1'b0, dlt_q});
   assign dn_nxt  = (dn_diff < $signed({1'b0, min_q})) ? min_q : dn_diff[N-1:0];

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      min_d   = min_q;
      max_d   = max_q;
      dlt_d   = dlt_q;
      hcfg_d  = hcfg_q;
      div_d   = div_q;
      hcnt_d  = hcnt_q;
      frm_d   = tick ? frm_q + 1'b1 : frm_q;
      unique case (state_q)
         ST_IDLE: begin
            duty_d = '0;
            if (enable) begin
               state_d = ST_UP;
               duty_d  = duty_min;
               min_d   = duty_min;
               max_d   = (duty_max > duty_min) ? duty_max : duty_min;
               dlt_d   = (delta == '0) ? N'(1) : delta;
               hcfg_d  = hold;
               div_d   = step_div;
            end
         end
         ST_UP: if (fe) begin
            if (!enable) begin
               state_d = ST_DOWN;
            end else begin
               duty_d = up_nxt;
               if (up_nxt == max_q) begin
                  state_d = ST_HOLD_HI;
                  hcnt_d  = hcfg_q;
               end
            end
         end
         ST_HOLD_HI: if (fe) begin
            if (!enable || hcnt_q == '0) state_d = ST_DOWN;
            else                         hcnt_d  = hcnt_q - 1'b1;
         end
         ST_DOWN: if (fe) begin
            duty_d = dn_nxt;
            if (dn_nxt == min_q) begin
               state_d = ST_HOLD_LO;
               hcnt_d  = hcfg_q;
            end
         end
         ST_HOLD_LO: if (fe) begin
            if (hcnt_q != '0) begin
               hcnt_d = hcnt_q - 1'b1;
            end else if (enable) begin
               state_d = ST_UP;
            end else begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            duty_d  = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         frm_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         dlt_q   <= '0;
         hcfg_q  <= '0;
         div_q   <= '0;
         hcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         frm_q   <= frm_d;
         min_q   <= min_d;
         max_q   <= max_d;
         dlt_q   <= dlt_d;
         hcfg_q  <= hcfg_d;
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         busy_q  <= busy_d;
      end
   end
endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader with N=4 (16-cycle frames at step_div=0).
module tb_pwm_fader;
   localparam int N  = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] step_div = '0;
   logic [DW-1:0] hold = 16'd1;
   logic [N-1:0]  duty_min = 4'd0;
   logic [N-1:0]  duty_max = 4'd12;
   logic [N-1:0]  delta = 4'd4;
   logic          pwm_ena, pwm_step, busy;
   logic [N-1:0]  pwm_duty;

   int checks = 0;
   int errors = 0;

   pwm_fader #(.N(N), .DIV_W(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .step_div (step_div),
      .duty_min (duty_min),
      .duty_max (duty_max),
      .delta    (delta),
      .hold     (hold),
      .pwm_ena  (pwm_ena),
      .pwm_step (pwm_step),
      .pwm_duty (pwm_duty),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      enable   = 1'b0;
      step_div = '0;
      hold     = 16'd1;
      duty_min = 4'd0;
      duty_max = 4'd12;
      delta    = 4'd4;
      rst      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Raise enable; returns in the first busy cycle (k+1).
   task automatic start_run();
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pwm_ena, pwm_step, busy, pwm_duty} !== 7'd0) begin
         errors++;
         $display("FAIL reset_held ena=%b step=%b busy=%b duty=%0d want all 0",
                  pwm_ena, pwm_step, busy, pwm_duty);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({pwm_ena, pwm_step, busy, pwm_duty} !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle c%0d ena=%b step=%b busy=%b duty=%0d want all 0",
                     i, pwm_ena, pwm_step, busy, pwm_duty);
         end
      end
   endtask

   task automatic test_full_cycle();
      int ex [12] = '{0, 4, 8, 12, 12, 12, 8, 4, 0, 0, 0, 4};
      apply_reset();
      start_run();
      for (int f = 0; f < 12; f++) begin
         for (int c = 0; c < 16; c++) begin
            checks++;
            if (pwm_duty !== N'(ex[f]) || pwm_step !== 1'b1 ||
                pwm_ena !== 1'b1 || busy !== 1'b1) begin
               errors++;
               $display("FAIL full_cycle f%0d c%0d duty=%0d step=%b ena=%b busy=%b want duty=%0d 1 1 1",
                        f, c, pwm_duty, pwm_step, pwm_ena, busy, ex[f]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_saturation();
      int ex5 [7] = '{0, 5, 10, 12, 12, 12, 7};
      int ex0 [4] = '{0, 1, 2, 3};
      apply_reset();
      delta = 4'd5;
      start_run();
      for (int f = 0; f < 7; f++) begin
         for (int c = 0; c < 16; c++) begin
            checks++;
            if (pwm_duty !== N'(ex5[f])) begin
               errors++;
               $display("FAIL sat_delta5 f%0d c%0d duty=%0d want %0d",
                        f, c, pwm_duty, ex5[f]);
            end
            @(negedge clk);
         end
      end
      apply_reset();
      delta = 4'd0;
      start_run();
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < 16; c++) begin
            checks++;
            if (pwm_duty !== N'(ex0[f])) begin
               errors++;
               $display("FAIL sat_delta0 f%0d c%0d duty=%0d want %0d",
                        f, c, pwm_duty, ex0[f]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_graceful_stop();
      int ex [7] = '{0, 4, 8, 8, 4, 0, 0};
      apply_reset();
      start_run();
      for (int f = 0; f < 7; f++) begin
         for (int c = 0; c < 16; c++) begin
            if (f == 2 && c == 5) begin
               enable   = 1'b0;
               duty_min = 4'd2;
               duty_max = 4'd15;
               delta    = 4'd1;
               hold     = 16'd5;
            end
            checks++;
            if (pwm_duty !== N'(ex[f]) || pwm_ena !== 1'b1 || busy !== 1'b1) begin
               errors++;
               $display("FAIL stop_fade f%0d c%0d duty=%0d ena=%b busy=%b want duty=%0d 1 1",
                        f, c, pwm_duty, pwm_ena, busy, ex[f]);
            end
            @(negedge clk);
         end
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({pwm_ena, pwm_step, busy, pwm_duty} !== 7'd0) begin
            errors++;
            $display("FAIL stop_idle c%0d ena=%b step=%b busy=%b duty=%0d want all 0",
                     i, pwm_ena, pwm_step, busy, pwm_duty);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_divider();
      logic          exp_step;
      logic [N-1:0]  exp_duty;
      apply_reset();
      step_div = 16'd2;
      start_run();
      for (int i = 0; i < 96; i++) begin
         exp_step = (i % 3 == 2);
         exp_duty = (i < 48) ? 4'd0 : 4'd4;
         checks++;
         if (pwm_step !== exp_step || pwm_duty !== exp_duty) begin
            errors++;
            $display("FAIL divider i%0d step=%b duty=%0d want step=%b duty=%0d",
                     i, pwm_step, pwm_duty, exp_step, exp_duty);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      start_run();
      repeat (37) @(negedge clk);
      checks++;
      if (pwm_duty !== 4'd8) begin
         errors++;
         $display("FAIL arst_pre duty=%0d want 8", pwm_duty);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({pwm_ena, pwm_step, busy, pwm_duty} !== 7'd0) begin
         errors++;
         $display("FAIL arst_async ena=%b step=%b busy=%b duty=%0d want all 0",
                  pwm_ena, pwm_step, busy, pwm_duty);
      end
      @(negedge clk);
      duty_min = 4'd3;
      rst      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         checks++;
         if (busy !== 1'b1 || pwm_ena !== 1'b1 ||
             pwm_duty !== ((i < 16) ? 4'd3 : 4'd7)) begin
            errors++;
            $display("FAIL arst_restart i%0d duty=%0d busy=%b ena=%b want duty=%0d 1 1",
                     i, pwm_duty, busy, pwm_ena, (i < 16) ? 3 : 7);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_saturation();
      test_graceful_stop();
      test_divider();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_fader.md
# pwm_fader

Sequencing controller for one `pwm` instance. It generates the `step` strobe from a programmable divider and ramps `duty` between two limits in a triangle pattern with programmable dwell at each extreme ("breathing" output). Duty changes only at PWM frame boundaries, so no output period is ever truncated. It sits between the register/config logic and the `pwm` instance, driving that instance's `ena`, `step` and `duty`.

## Interface
- `N`, default 8: duty width. Must match the `pwm` instance's `N`.
- `DIV_W`, default 16: width of `step_div` and `hold`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level run request.
- `step_div`  in  DIV_W  emit one `pwm_step` every `step_div+1` cycles.
- `duty_min`  in  N  lower ramp limit.
- `duty_max`  in  N  upper ramp limit.
- `delta`  in  N  duty change per frame. A value of 0 is treated as 1.
- `hold`  in  DIV_W  frames to dwell at each extreme.
- `pwm_ena`  out  1  to `pwm.ena`.
- `pwm_step`  out  1  to `pwm.step`; single-cycle pulse.
- `pwm_duty`  out  N  to `pwm.duty`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- **States:** IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- **Shadow configuration:** all config inputs are captured into shadow registers on IDLE→UP. Changes during a run are ignored.
  - Effective `max` = larger of `duty_max` and `duty_min`.
- **Frame counter:**
  - Internal N-bit counter that mirrors the pwm counter. It increments when `pwm_ena & pwm_step`.
  - It is cleared only by reset and wraps at 2^N-1→0.
  - Frame end (FE) = a cycle where a step occurs with the counter at 2^N-1.
- **Divider:**
  - Counts 0..`step_div`. It is held at 0 in IDLE.
  - `pwm_step` is high for the cycle in which the count equals `step_div`; the count then returns to 0.
- **IDLE:**
  - `pwm_ena`=0 and `pwm_duty`=0.
  - `enable`=1 → UP, with `pwm_duty`=`duty_min`.
- **UP:**
  - At each FE, `pwm_duty` = min(duty+delta, max). The sum is computed in N+1 bits, so there is no wrap.
  - When the updated value equals max → HOLD_HI, and the hold counter is loaded with `hold`.
- **HOLD_HI:**
  - At each FE: if the hold counter is 0 → DOWN; otherwise decrement it.
  - `hold`=0 therefore leaves at the first FE.
- **DOWN:**
  - At each FE, `pwm_duty` = max(duty−delta, min). The difference is computed in signed N+1 bits, so there is no underflow.
  - When the value equals min → HOLD_LO, and the hold counter is loaded.
- **HOLD_LO:** same dwell rule as HOLD_HI. On exit, go to UP if `enable`=1, else to IDLE.
- **Graceful stop:** `enable`=0 in UP or HOLD_HI forces → DOWN at the next FE. The duty is unchanged on that FE. The block then fades down normally and exits to IDLE from HOLD_LO.
- **min = max:** UP→HOLD_HI occurs at the first FE with duty unchanged.

## Timing
- **Reset:** while `rst`=0, outputs are forced immediately (async): `pwm_ena`=0, `pwm_step`=0, `pwm_duty`=0, `busy`=0, state IDLE, and all counters 0. Reset mid-run aborts with no fade.
- **Start:** `enable` is sampled at edge k. From cycle k+1, `busy`=1, `pwm_ena`=1 and `pwm_duty`=`duty_min`.
- **First step:** the first `pwm_step` occurs in cycle k+1+`step_div`.
- **Frame length:** one frame is 2^N·(`step_div`+1) cycles.
- **Duty latency:** a duty update is registered on the FE edge. The new value is visible from the cycle after the FE, i.e. coincident with frame counter = 0.
- **Return to IDLE:** `pwm_ena` and `busy` drop in the cycle after the final HOLD_LO FE.
- **Registered outputs:** all outputs are registered with no combinational input→output path.

## Structure
- **Package `pwm_fader_pkg`:** holds the state enum typedef (`fader_state_t`, 3-bit) and the state encodings.
- **Sub-module `tick_div`:** the divider, with ports `clk`, `rst`, `run`, `div`, and `tick` out.
- **Not instantiated here:** the `pwm` instance is not instantiated inside this block. The parent wires it, with the pwm reset driven from `~rst`.

## Test plan
Bench parameters: N=4, `step_div`=0, `duty_min`=0, `duty_max`=12, `delta`=4, `hold`=1. One frame = 16 cycles.
- **Reset:** hold `rst`=0 for 3 cycles, release → all outputs 0, `busy`=0, no `pwm_step` while `enable`=0.
- **Full cycle:** raise `enable` → duty sequence 0,4,8,12 (one value per frame), 12 for 2 more frames, then 8,4,0, 0 for 2 frames, 4… Every change is aligned to the frame counter reaching 0.
- **Saturation:** `delta`=5 → 0,5,10,12, then HOLD_HI. `delta`=0 → increments by 1.
- **Graceful stop:** drop `enable` while duty=8 in UP → duty stays 8 for that FE, then 4,0, 0 for 2 frames, then `pwm_ena`=0 and `busy`=0. Config changes mid-run have no effect.
- **Divider:** `step_div`=2 → `pwm_step` high exactly every 3rd cycle, first at cycle k+3. Frame = 48 cycles.
- **Async reset mid-run:** assert `rst` low between edges while duty=8 → outputs read 0 before the next edge. Release with `enable`=1 → restarts at `duty_min`.
